// File: rtl/sdram_line_sequencer.sv
// Cache-line sequencer for the Gowin SDRAM controller user interface: ACTIVE, then one fixed-length READ/WRITE burst.
// Optional macro SDRAM_LINE_SEQUENCER_ACK_CHECK_EN gates timed exits on sdrc_cmd_ack and adds the sticky ack_err output.
`timescale 1ns/1ps
module sdram_line_sequencer #(
  parameter int BURST_LEN    = 8,
  parameter int ACT_WAIT     = 4,
  parameter int READ_LATENCY = 4,
  parameter int WR_RECOVERY  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sdrc_init_done,
  input  logic                         req,
  input  logic                         we,
  input  logic [20:0]                  addr,
  output logic [$clog2(BURST_LEN)-1:0] word_idx,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata,
  output logic                         rdata_valid,
  output logic                         done,
  output logic                         busy,
  output logic                         sdrc_cmd_en,
  output logic [2:0]                   sdrc_cmd,
  output logic [20:0]                  sdrc_addr,
  output logic [7:0]                   sdrc_data_len,
  output logic [3:0]                   sdrc_dqm,
  output logic [31:0]                  sdrc_wdata,
  input  logic [31:0]                  sdrc_rdata,
  input  logic                         sdrc_cmd_ack,
`ifdef SDRAM_LINE_SEQUENCER_ACK_CHECK_EN
  output logic                         ack_err,
`endif
  output logic                         sdrc_precharge_ctrl,
  output logic                         sdrc_power_down,
  output logic                         sdrc_selfrefresh
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int MAX_A = (ACT_WAIT > READ_LATENCY) ? ACT_WAIT : READ_LATENCY;
  localparam int MAX_B = (BURST_LEN > WR_RECOVERY) ? BURST_LEN : WR_RECOVERY;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P + 1);

  // Counters load "cycles remaining minus one" so every timed state exits on zero.
  localparam logic [CNT_W-1:0] ACT_CNT   = CNT_W'(ACT_WAIT - 2);
  localparam logic [CNT_W-1:0] RD_CNT    = CNT_W'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] REC_CNT   = CNT_W'((WR_RECOVERY >= 1) ? WR_RECOVERY - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BURST_LEN - 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ACT, S_ACT_WAIT, S_RW, S_WR_DATA,
    S_RECOVER, S_RD_WAIT, S_RD_DATA, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [20:0]      line_addr_q, line_addr_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             ack_ok;
  logic             unused_bits;

`ifdef SDRAM_LINE_SEQUENCER_ACK_CHECK_EN
  logic ack_err_q, ack_err_d;
  assign ack_ok      = sdrc_cmd_ack;
  assign ack_err     = ack_err_q;
  assign unused_bits = &{1'b0, addr[IDX_W-1:0]};
  always_comb begin
    ack_err_d = ack_err_q;
    if ((state_q == S_ACT_WAIT || state_q == S_RECOVER) && cnt_q == '0 && !sdrc_cmd_ack)
      ack_err_d = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_err_q <= 1'b0;
    else     ack_err_q <= ack_err_d;
  end
`else
  assign ack_ok      = 1'b1;
  assign unused_bits = &{1'b0, sdrc_cmd_ack, addr[IDX_W-1:0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      line_addr_q   <= '0;
      word_idx_q    <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      line_addr_q   <= line_addr_d;
      word_idx_q    <= word_idx_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    line_addr_d = line_addr_q;
    case (state_q)
      S_INIT: if (sdrc_init_done) state_d = S_IDLE;
      S_IDLE: if (req) begin
        we_d        = we;
        line_addr_d = {addr[20:IDX_W], {IDX_W{1'b0}}};
        state_d     = S_ACT;
      end
      S_ACT: begin
        cnt_d   = ACT_CNT;
        state_d = S_ACT_WAIT;
      end
      S_ACT_WAIT: begin
        if (cnt_q != '0)  cnt_d   = cnt_q - CNT_W'(1);
        else if (ack_ok)  state_d = S_RW;
      end
      S_RW: begin
        if (we_q) state_d = S_WR_DATA;
        else if (READ_LATENCY > 1) begin
          state_d = S_RD_WAIT;
          cnt_d   = RD_CNT;
        end else begin
          state_d = S_RD_DATA;
          cnt_d   = BURST_CNT;
        end
      end
      S_WR_DATA: if (word_idx_q == LAST_IDX) begin
        state_d = S_RECOVER;
        cnt_d   = REC_CNT;
      end
      S_RECOVER: begin
        if (cnt_q != '0)  cnt_d   = cnt_q - CNT_W'(1);
        else if (ack_ok)  state_d = S_DONE;
      end
      S_RD_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          state_d = S_RD_DATA;
          cnt_d   = BURST_CNT;
        end
      end
      S_RD_DATA: begin
        if (cnt_q != '0) cnt_d   = cnt_q - CNT_W'(1);
        else             state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Read words surface one cycle after capture, so the index follows rdata_valid rather than the state.
  always_comb begin
    rdata_valid_d = (state_q == S_RD_DATA);
    rdata_d       = (state_q == S_RD_DATA) ? sdrc_rdata : rdata_q;
    word_idx_d    = word_idx_q;
    if ((state_q == S_RW && we_q) || state_q == S_WR_DATA || rdata_valid_q)
      word_idx_d = word_idx_q + IDX_W'(1);
  end

  always_comb begin
    sdrc_cmd_en = 1'b0;
    sdrc_cmd    = 3'b000;
    sdrc_addr   = '0;
    sdrc_wdata  = '0;
    case (state_q)
      S_ACT: begin
        sdrc_cmd_en = 1'b1;
        sdrc_cmd    = 3'b011;
        sdrc_addr   = line_addr_q;
      end
      S_RW: begin
        sdrc_cmd_en = 1'b1;
        sdrc_cmd    = we_q ? 3'b100 : 3'b101;
        sdrc_addr   = line_addr_q;
        if (we_q) sdrc_wdata = wdata;
      end
      S_WR_DATA: sdrc_wdata = wdata;
      default: ;
    endcase
  end

  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_DONE);
  assign word_idx            = word_idx_q;
  assign rdata               = rdata_q;
  assign rdata_valid         = rdata_valid_q;
  assign sdrc_data_len       = 8'(BURST_LEN - 1);
  assign sdrc_dqm            = 4'b0000;
  assign sdrc_precharge_ctrl = 1'b1;
  assign sdrc_power_down     = 1'b0;
  assign sdrc_selfrefresh    = 1'b0;

endmodule

// File: tb/tb_sdram_line_sequencer.sv
// Scoreboard bench for sdram_line_sequencer: directed line transfers against a small SDRAM memory model.
`timescale 1ns/1ps
module tb_sdram_line_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdrc_init_done = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [20:0] addr = '0;
  logic [2:0]  word_idx;
  logic [31:0] wdata, rdata, sdrc_wdata;
  logic [31:0] sdrc_rdata = '0;
  logic        rdata_valid, done, busy, sdrc_cmd_en;
  logic [2:0]  sdrc_cmd;
  logic [20:0] sdrc_addr;
  logic [7:0]  sdrc_data_len;
  logic [3:0]  sdrc_dqm;
  logic        sdrc_cmd_ack = 1'b0;
  logic        sdrc_precharge_ctrl, sdrc_power_down, sdrc_selfrefresh;

  sdram_line_sequencer dut (
    .clk(clk), .rst(rst), .sdrc_init_done(sdrc_init_done), .req(req), .we(we),
    .addr(addr), .word_idx(word_idx), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .done(done), .busy(busy), .sdrc_cmd_en(sdrc_cmd_en),
    .sdrc_cmd(sdrc_cmd), .sdrc_addr(sdrc_addr), .sdrc_data_len(sdrc_data_len),
    .sdrc_dqm(sdrc_dqm), .sdrc_wdata(sdrc_wdata), .sdrc_rdata(sdrc_rdata),
    .sdrc_cmd_ack(sdrc_cmd_ack), .sdrc_precharge_ctrl(sdrc_precharge_ctrl),
    .sdrc_power_down(sdrc_power_down), .sdrc_selfrefresh(sdrc_selfrefresh)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] lineA [8] = '{32'h1234_5678, 32'habcd_ef01, 32'h5678_1010, 32'habcd_fefe,
                             32'habce_ef01, 32'habcd_ef02, 32'habcd_ef03, 32'habcd_ef04};
  logic [31:0] lineB [8] = '{32'h1010_2020, 32'habcd_ef01, 32'h5678_1010, 32'habcd_fefe,
                             32'habce_ef01, 32'habcd_ef02, 32'habcd_ef03, 32'habcd_ef04};
  logic [31:0] line_buf [8];
  assign wdata = line_buf[word_idx];

  typedef struct { int cyc; logic [2:0] cmd; logic [20:0] a; } cmd_exp_t;
  typedef struct { int cyc; logic [31:0] d; } wr_exp_t;
  typedef struct { int cyc; int idx; logic [31:0] d; } rd_exp_t;
  cmd_exp_t cmd_q [$];
  wr_exp_t  wr_q  [$];
  rd_exp_t  rd_q  [$];
  int       done_q [$];

  int checks = 0;
  int passes = 0;

  // Checking tasks
  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic goToCycle(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] lineWord(int sel, int k);
    return (sel == 0) ? lineA[k] : lineB[k];
  endfunction

  task automatic raiseInitAt(int n);
    goToCycle(n);
    checkOutput("init_hold_busy", 32'(busy), 32'd1);
    checkOutput("init_hold_cmd_en", 32'(sdrc_cmd_en), 32'd0);
    sdrc_init_done = 1'b1;
  endtask

  // Drives one line request at cycle drv; ACTIVE is expected at t_act, the line address is hand-given.
  task automatic applyStimulus(int drv, int t_act, bit we_i, logic [20:0] a, logic [20:0] la,
                               int sel, bit keep, int n_words);
    goToCycle(drv);
    we   = we_i;
    addr = a;
    if (we_i) for (int k = 0; k < 8; k++) line_buf[k] = lineWord(sel, k);
    req = 1'b1;
    cmd_q.push_back('{t_act, 3'b011, la});
    cmd_q.push_back('{t_act + 4, we_i ? 3'b100 : 3'b101, la});
    if (we_i) for (int k = 0; k < n_words; k++) wr_q.push_back('{t_act + 4 + k, lineWord(sel, k)});
    else      for (int k = 0; k < 8; k++) rd_q.push_back('{t_act + 9 + k, k, lineWord(sel, k)});
    if (n_words == 8) begin
      done_q.push_back(t_act + 16);
      goToCycle(t_act + 16);
      if (!keep) req = 1'b0;
    end
  endtask

  // Monitor plus SDRAM memory model, both on the falling edge
  logic [31:0] mem [int];
  int          rd_start = -100, wr_start = -100;
  logic [20:0] rd_base = '0, wr_base = '0;
  cmd_exp_t    ce;
  wr_exp_t     we_e;
  rd_exp_t     re;
  int          de;

  always @(negedge clk) begin
    if (sdrc_cmd_en) begin
      if (cmd_q.size() == 0) checkOutput("unexpected_cmd_en", 32'(sdrc_cmd_en), 32'd0);
      else begin
        ce = cmd_q.pop_front();
        checkOutput("cmd", 32'(sdrc_cmd), 32'(ce.cmd));
        checkOutput("cmd_addr", 32'(sdrc_addr), 32'(ce.a));
        checkOutput("cmd_cycle", 32'(cyc), 32'(ce.cyc));
        checkOutput("data_len", 32'(sdrc_data_len), 32'd7);
      end
    end
    if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
      we_e = wr_q.pop_front();
      checkOutput("sdrc_wdata", sdrc_wdata, we_e.d);
    end
    if (rdata_valid) begin
      if (rd_q.size() == 0) checkOutput("unexpected_rdata_valid", 32'(rdata_valid), 32'd0);
      else begin
        re = rd_q.pop_front();
        checkOutput("rdata", rdata, re.d);
        checkOutput("rdata_idx", 32'(word_idx), 32'(re.idx));
        checkOutput("rdata_cycle", 32'(cyc), 32'(re.cyc));
      end
    end
    if (done) begin
      if (done_q.size() == 0) checkOutput("unexpected_done", 32'(done), 32'd0);
      else begin
        de = done_q.pop_front();
        checkOutput("done_cycle", 32'(cyc), 32'(de));
      end
    end
    if (rst) begin
      rd_start = -100;
      wr_start = -100;
    end else if (sdrc_cmd_en && sdrc_cmd == 3'b101) begin
      rd_start = cyc + 4;
      rd_base  = sdrc_addr;
    end else if (sdrc_cmd_en && sdrc_cmd == 3'b100) begin
      wr_start = cyc;
      wr_base  = sdrc_addr;
    end
    if (cyc >= wr_start && cyc < wr_start + 8) mem[int'(wr_base) + cyc - wr_start] = sdrc_wdata;
    if (cyc >= rd_start && cyc < rd_start + 8) sdrc_rdata = mem[int'(rd_base) + cyc - rd_start];
    else                                       sdrc_rdata = 32'hdead_0000 | 32'(cyc[15:0]);
  end

  initial begin
    goToCycle(1);
    checkOutput("rst_cmd_en", 32'(sdrc_cmd_en), 32'd0);
    checkOutput("rst_cmd", 32'(sdrc_cmd), 32'd0);
    checkOutput("rst_addr", 32'(sdrc_addr), 32'd0);
    checkOutput("rst_word_idx", 32'(word_idx), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_wdata", sdrc_wdata, 32'd0);
    checkOutput("rst_dqm", 32'(sdrc_dqm), 32'd0);
    checkOutput("rst_precharge", 32'(sdrc_precharge_ctrl), 32'd1);
    checkOutput("rst_power_down", 32'(sdrc_power_down), 32'd0);
    checkOutput("rst_selfrefresh", 32'(sdrc_selfrefresh), 32'd0);
    goToCycle(3);
    rst = 1'b0;

    fork raiseInitAt(50); join_none
    applyStimulus(10, 52, 1'b1, 21'h000, 21'h000, 0, 1'b0, 8);
    applyStimulus(70, 71, 1'b1, 21'h100, 21'h100, 1, 1'b0, 8);
    applyStimulus(90, 91, 1'b0, 21'h000, 21'h000, 0, 1'b0, 8);
    applyStimulus(110, 111, 1'b0, 21'h105, 21'h100, 1, 1'b1, 8);
    applyStimulus(127, 129, 1'b1, 21'h200, 21'h200, 0, 1'b0, 8);
    applyStimulus(150, 151, 1'b0, 21'h200, 21'h200, 0, 1'b0, 8);

    // Reset lands on word 3 of a write burst (RW at 175)
    applyStimulus(170, 171, 1'b1, 21'h300, 21'h300, 1, 1'b0, 3);
    goToCycle(178);
    rst = 1'b1;
    req = 1'b0;
    sdrc_init_done = 1'b0;
    #1;
    checkOutput("abort_cmd_en", 32'(sdrc_cmd_en), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd1);
    checkOutput("abort_word_idx", 32'(word_idx), 32'd0);
    checkOutput("abort_wdata", sdrc_wdata, 32'd0);
    goToCycle(180);
    rst = 1'b0;

    fork raiseInitAt(190); join_none
    applyStimulus(185, 192, 1'b1, 21'h300, 21'h300, 0, 1'b0, 8);
    applyStimulus(210, 211, 1'b0, 21'h300, 21'h300, 0, 1'b0, 8);

    goToCycle(235);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("pending_cmds", 32'(cmd_q.size()), 32'd0);
    checkOutput("pending_wdata", 32'(wr_q.size()), 32'd0);
    checkOutput("pending_rdata", 32'(rd_q.size()), 32'd0);
    checkOutput("pending_done", 32'(done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    checks++;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required finish by 235", cyc);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
